// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction field positions, default widths
// and the fetch handshake state encoding.
package sisc_pkg;

  localparam int PC_W_DEFAULT    = 16;
  localparam int INSTR_W_DEFAULT = 32;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int MM_HI  = 27;
  localparam int MM_LO  = 24;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

  typedef enum logic [3:0] {
    NOOP = 4'd0,  ALU  = 4'd1,  LDI  = 4'd2,  LD   = 4'd3,
    ST   = 4'd4,  BRA  = 4'd5,  BRR  = 4'd6,  BNE  = 4'd7,
    BRE  = 4'd8,  JSR  = 4'd9,  RTS  = 4'd10, PSH  = 4'd11,
    POP  = 4'd12, INP  = 4'd13, OUTP = 4'd14, HLT  = 4'd15
  } opcode_e;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter register with next-PC selection: reset, increment,
// absolute branch or PC-relative branch; all arithmetic wraps modulo 2^PC_W.
module pc_unit
  import sisc_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             pc_rst,
  input  logic             pc_write,
  input  logic             pc_sel,
  input  logic             br_sel,
  input  logic [IMM_W-1:0] imm,
  output logic [PC_W-1:0]  pc
);

  logic [PC_W-1:0] imm_zext;
  logic [PC_W-1:0] imm_sext;
  logic [PC_W-1:0] pc_nxt;

  assign imm_zext = PC_W'(imm);
  assign imm_sext = PC_W'($signed(imm));

  always_comb begin
    pc_nxt = pc;
    if (pc_rst) begin
      pc_nxt = RESET_PC;
    end else if (pc_write) begin
      if (!pc_sel)     pc_nxt = pc + PC_W'(1);
      else if (br_sel) pc_nxt = imm_zext;
      else             pc_nxt = pc + imm_sext;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) pc <= RESET_PC;
    else        pc <= pc_nxt;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch responder: owns PC and IR, runs a req/ack read against
// instruction memory with a REQ timeout and a sticky fault flag.
//   state   | meaning
//   FS_IDLE | no fetch outstanding, waiting for ir_load
//   FS_REQ  | imem_req high at fetch_addr, waiting for imem_ack or timeout
module fetch_unit
  import sisc_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter int              INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [PC_W-1:0]    pc_out,
  output logic               fetch_busy,
  output logic               fetch_fault
);

  localparam int CNT_W = 8;

  fetch_state_e       state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [INSTR_W-1:0] ir_nxt;
  logic [PC_W-1:0]    addr_nxt;
  logic               fault_nxt;

  pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_f    (rst_f),
    .pc_rst   (pc_rst),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .br_sel   (br_sel),
    .imm      (ir[IMM_HI:IMM_LO]),
    .pc       (pc_out)
  );

  // Timeout is a down-counter loaded on REQ entry; terminal count 0 with no ack
  // means TIMEOUT REQ cycles have elapsed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ir_nxt    = ir;
    addr_nxt  = imem_addr;
    fault_nxt = fetch_fault;
    if (pc_rst) begin
      state_nxt = FS_IDLE;
      cnt_nxt   = '0;
      ir_nxt    = '0;
      fault_nxt = 1'b0;
    end else begin
      case (state)
        FS_IDLE: begin
          if (ir_load) begin
            state_nxt = FS_REQ;
            addr_nxt  = pc_out;
            cnt_nxt   = CNT_W'(TIMEOUT - 1);
          end
        end
        FS_REQ: begin
          if (ir_load) fault_nxt = 1'b1;
          if (imem_ack) begin
            state_nxt = FS_IDLE;
            ir_nxt    = imem_rdata;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            state_nxt = FS_IDLE;
            ir_nxt    = '0;
            fault_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: state_nxt = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state       <= FS_IDLE;
      cnt         <= '0;
      ir          <= '0;
      imem_addr   <= '0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ir          <= ir_nxt;
      imem_addr   <= addr_nxt;
      fetch_fault <= fault_nxt;
    end
  end

  assign imem_req   = (state == FS_REQ);
  assign fetch_busy = (state == FS_REQ);
  assign opcode     = ir[OPC_HI:OPC_LO];
  assign mm         = ir[MM_HI:MM_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; fetch responses are checked by a monitor
// against queues of expected request addresses and completion results.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0;
  logic        ir_load = 1'b0, imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, fetch_busy, fetch_fault;
  logic [15:0] imem_addr, pc_out;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] addr_q[$];
  logic [32:0] done_q[$];   // {fault, ir}

  fetch_unit #(.PC_W(16), .INSTR_W(32), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
    .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .opcode(opcode), .mm(mm),
    .pc_out(pc_out), .fetch_busy(fetch_busy), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    imem_ack = 1'b0;
  endtask

  // Single-cycle-latency fetch: ir_load (optionally with PC increment), ack next cycle.
  task automatic do_fetch(input logic [15:0] exp_addr, input logic [31:0] rdata,
                          input logic inc, input logic exp_fault);
    addr_q.push_back(exp_addr);
    ir_load = 1'b1; pc_write = inc; pc_sel = 1'b0;
    tick();
    idle_inputs();
    imem_ack = 1'b1; imem_rdata = rdata;
    done_q.push_back({exp_fault, rdata});
    tick();
    idle_inputs();
  endtask

  task automatic branch(input logic abs);
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = abs;
    tick();
    idle_inputs();
  endtask

  // Monitor: a rising imem_req is a new request, a falling one is a completion.
  logic req_q = 1'b0;
  always @(negedge clk or negedge rst_f) begin
    if (imem_req === 1'b1 && req_q === 1'b0) begin
      if (addr_q.size() == 0) chk("unexpected_request", 32'(imem_addr), 32'hFFFF_FFFF);
      else chk("imem_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
    end
    if (imem_req === 1'b0 && req_q === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("unexpected_completion", ir, 32'hFFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = done_q.pop_front();
        chk("done_ir", ir, e[31:0]);
        chk("done_fault", 32'(fetch_fault), 32'(e[32]));
      end
    end
    req_q = imem_req;
  end

  initial begin
    #1 rst_f = 1'b0;
    #2;
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    tick(); tick();
    rst_f = 1'b1;
    tick();

    // 1: normal fetch with PC increment
    addr_q.push_back(16'h0000);
    ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    tick();
    idle_inputs();
    chk("t1_busy", 32'(fetch_busy), 32'h1);
    imem_ack = 1'b1; imem_rdata = 32'h1A00_0005;
    done_q.push_back({1'b0, 32'h1A00_0005});
    tick();
    idle_inputs();
    chk("t1_ir", ir, 32'h1A00_0005);
    chk("t1_opcode", 32'(opcode), 32'h1);
    chk("t1_mm", 32'(mm), 32'hA);
    chk("t1_pc", 32'(pc_out), 32'h0001);
    chk("t1_req", 32'(imem_req), 32'h0);

    // ack while idle is ignored
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    chk("idle_ack_ir", ir, 32'h1A00_0005);
    chk("idle_ack_busy", 32'(fetch_busy), 32'h0);

    // 2: absolute, relative, absolute branches
    do_fetch(16'h0001, 32'h6000_0010, 1'b0, 1'b0);
    branch(1'b1);
    chk("t2_abs_pc", 32'(pc_out), 32'h0010);
    do_fetch(16'h0010, 32'h5000_FFFE, 1'b0, 1'b0);
    branch(1'b0);
    chk("t2_rel_pc", 32'(pc_out), 32'h000E);
    do_fetch(16'h000E, 32'h6000_0040, 1'b0, 1'b0);
    branch(1'b1);
    chk("t2_abs2_pc", 32'(pc_out), 32'h0040);

    // 3: wrap at 0xFFFF
    do_fetch(16'h0040, 32'h6000_FFFF, 1'b0, 1'b0);
    branch(1'b1);
    chk("t3_pc_ffff", 32'(pc_out), 32'hFFFF);
    pc_write = 1'b1; pc_sel = 1'b0;
    tick();
    idle_inputs();
    chk("t3_wrap", 32'(pc_out), 32'h0000);

    // branch on the ack edge uses the old ir
    addr_q.push_back(16'h0000);
    ir_load = 1'b1;
    tick();
    idle_inputs();
    imem_ack = 1'b1; imem_rdata = 32'h6000_0123;
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    done_q.push_back({1'b0, 32'h6000_0123});
    tick();
    idle_inputs();
    chk("same_edge_pc", 32'(pc_out), 32'hFFFF);
    chk("same_edge_ir", ir, 32'h6000_0123);

    // 4: timeout after 15 REQ cycles
    addr_q.push_back(16'hFFFF);
    ir_load = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 14; i++) tick();
    chk("t4_req_before", 32'(imem_req), 32'h1);
    chk("t4_fault_before", 32'(fetch_fault), 32'h0);
    done_q.push_back({1'b1, 32'h0});
    tick();
    chk("t4_req_after", 32'(imem_req), 32'h0);
    chk("t4_ir", ir, 32'h0);
    chk("t4_fault", 32'(fetch_fault), 32'h1);
    pc_rst = 1'b1;
    tick();
    idle_inputs();
    chk("t4_rst_fault", 32'(fetch_fault), 32'h0);
    chk("t4_rst_pc", 32'(pc_out), 32'h0000);

    // 5: overrun ir_load while in REQ, with a PC increment during REQ
    addr_q.push_back(16'h0000);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    tick();
    idle_inputs();
    chk("t5_addr", 32'(imem_addr), 32'h0000);
    chk("t5_fault", 32'(fetch_fault), 32'h1);
    chk("t5_busy", 32'(fetch_busy), 32'h1);
    chk("t5_pc", 32'(pc_out), 32'h0001);
    imem_ack = 1'b1; imem_rdata = 32'h2000_0777;
    done_q.push_back({1'b1, 32'h2000_0777});
    tick();
    idle_inputs();
    chk("t5_ir", ir, 32'h2000_0777);
    chk("t5_opcode", 32'(opcode), 32'h2);

    // 6: pc_rst with ack on the same edge, then rst_f mid-fetch
    addr_q.push_back(16'h0001);
    ir_load = 1'b1;
    tick();
    idle_inputs();
    pc_rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; pc_write = 1'b1;
    done_q.push_back({1'b0, 32'h0});
    tick();
    idle_inputs();
    chk("t6_ir", ir, 32'h0);
    chk("t6_req", 32'(imem_req), 32'h0);
    chk("t6_busy", 32'(fetch_busy), 32'h0);
    chk("t6_pc", 32'(pc_out), 32'h0000);
    chk("t6_fault", 32'(fetch_fault), 32'h0);

    addr_q.push_back(16'h0000);
    ir_load = 1'b1;
    tick();
    idle_inputs();
    chk("t6_req_up", 32'(imem_req), 32'h1);
    done_q.push_back({1'b0, 32'h0});
    #1 rst_f = 1'b0;
    #1;
    chk("t6_async_req", 32'(imem_req), 32'h0);
    tick();
    rst_f = 1'b1;
    tick(); tick();
    chk("t6_post_pc", 32'(pc_out), 32'h0000);
    chk("addr_q_empty", 32'(addr_q.size()), 32'h0);
    chk("done_q_empty", 32'(done_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
